// File: rtl/arbitro_tx_serial_pkg.sv
// rtl/arbitro_tx_serial_pkg.sv - shared state codes, channel ids and defaults for the serial TX arbiter
package arbitro_tx_serial_pkg;

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    PARTIDA   = 3'd1,
    ESPERA    = 3'd2,
    FIM       = 3'd3,
    ERRO      = 3'd4,
    INTERVALO = 3'd5
  } estado_e;

  localparam logic CANAL_A = 1'b0;
  localparam logic CANAL_B = 1'b1;

  localparam int TIMEOUT_PADRAO = 8192;
  localparam int GAP_PADRAO     = 2;
  localparam int BITS_QUADRO    = 10;

  // One counter serves both the watchdog and the gap, so size it for the larger terminal.
  function automatic int largura_contador(input int t, input int g);
    int m;
    m = (t > g) ? t : g;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/arbitro_tx_serial_contador_m.sv
// rtl/arbitro_tx_serial_contador_m.sv - saturating up-counter with clear, enable and terminal flag
module contador_m
  import arbitro_tx_serial_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  input  logic [W-1:0] limite,
  output logic         fim
);

  logic [W-1:0] valor_q, valor_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) valor_q <= '0;
    else        valor_q <= valor_d;
  end

  always_comb begin
    valor_d = valor_q;
    if (zera)                          valor_d = '0;
    else if (conta && valor_q < limite) valor_d = valor_q + 1'b1;
  end

  assign fim = (valor_q == limite);

endmodule

// File: rtl/arbitro_tx_serial.sv
// rtl/arbitro_tx_serial.sv - round-robin arbiter sharing one 7O1 serial transmitter between channels A and B
module arbitro_tx_serial
  import arbitro_tx_serial_pkg::*;
#(
  parameter int TIMEOUT_CICLOS = TIMEOUT_PADRAO,
  parameter int GAP_CICLOS     = GAP_PADRAO
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pedido_a,
  input  logic [6:0] dado_a,
  output logic       aceito_a,
  output logic       fim_a,
  input  logic       pedido_b,
  input  logic [6:0] dado_b,
  output logic       aceito_b,
  output logic       fim_b,
  output logic       tx_partida,
  output logic [6:0] tx_dados,
  input  logic       tx_pronto,
  output logic       ocupado,
  output logic       erro,
  output logic [3:0] db_estado,
  output logic       db_vez
);

  localparam int CW = largura_contador(TIMEOUT_CICLOS, GAP_CICLOS);

  estado_e    estado_q, estado_d;
  logic       vez_q, vez_d;
  logic       dono_q, dono_d;
  logic [6:0] dados_q, dados_d;
  logic       dono_sel;
  logic       cnt_zera, cnt_conta, cnt_fim;
  logic [CW-1:0] cnt_limite;

  // Terminal count switches with the state: watchdog while waiting, gap afterwards.
  assign cnt_limite = (estado_q == ESPERA) ? CW'(TIMEOUT_CICLOS - 1) : CW'(GAP_CICLOS - 1);

  contador_m #(.W(CW)) u_contador (
    .clock  (clock),
    .reset  (reset),
    .zera   (cnt_zera),
    .conta  (cnt_conta),
    .limite (cnt_limite),
    .fim    (cnt_fim)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= OCIOSO;
      vez_q    <= CANAL_A;
      dono_q   <= CANAL_A;
      dados_q  <= '0;
    end else begin
      estado_q <= estado_d;
      vez_q    <= vez_d;
      dono_q   <= dono_d;
      dados_q  <= dados_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    vez_d     = vez_q;
    dono_d    = dono_q;
    dados_d   = dados_q;
    dono_sel  = (pedido_a && pedido_b) ? vez_q : pedido_b;
    cnt_zera  = 1'b0;
    cnt_conta = 1'b0;
    case (estado_q)
      OCIOSO: begin
        cnt_zera = 1'b1;
        if (pedido_a || pedido_b) begin
          dono_d   = dono_sel;
          dados_d  = (dono_sel == CANAL_B) ? dado_b : dado_a;
          estado_d = PARTIDA;
        end
      end
      PARTIDA: begin
        cnt_zera = 1'b1;
        estado_d = ESPERA;
      end
      ESPERA: begin
        if (tx_pronto)    estado_d = FIM;
        else if (cnt_fim) estado_d = ERRO;
        else              cnt_conta = 1'b1;
      end
      FIM, ERRO: begin
        cnt_zera = 1'b1;
        vez_d    = ~dono_q;
        estado_d = INTERVALO;
      end
      INTERVALO: begin
        if (cnt_fim) estado_d = OCIOSO;
        else         cnt_conta = 1'b1;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign tx_partida = (estado_q == PARTIDA);
  assign aceito_a   = (estado_q == PARTIDA) && (dono_q == CANAL_A);
  assign aceito_b   = (estado_q == PARTIDA) && (dono_q == CANAL_B);
  assign fim_a      = (estado_q == FIM) && (dono_q == CANAL_A);
  assign fim_b      = (estado_q == FIM) && (dono_q == CANAL_B);
  assign erro       = (estado_q == ERRO);
  assign ocupado    = (estado_q != OCIOSO);
  assign tx_dados   = dados_q;
  assign db_estado  = {1'b0, estado_q};
  assign db_vez     = vez_q;

endmodule

// File: tb/tb_arbitro_tx_serial.sv
// tb/tb_arbitro_tx_serial.sv - directed self-checking bench for arbitro_tx_serial with a 1-cycle-per-bit transmitter model
module tb_arbitro_tx_serial;

  logic       clock, reset;
  logic       pedido_a, pedido_b;
  logic [6:0] dado_a, dado_b;
  logic       aceito_a, aceito_b, fim_a, fim_b;
  logic       tx_partida, tx_pronto, ocupado, erro, db_vez;
  logic [6:0] tx_dados;
  logic [3:0] db_estado;

  int checks   = 0;
  int failures = 0;
  int ncic     = 0;

  arbitro_tx_serial #(.TIMEOUT_CICLOS(16), .GAP_CICLOS(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .pedido_a   (pedido_a),
    .dado_a     (dado_a),
    .aceito_a   (aceito_a),
    .fim_a      (fim_a),
    .pedido_b   (pedido_b),
    .dado_b     (dado_b),
    .aceito_b   (aceito_b),
    .fim_b      (fim_b),
    .tx_partida (tx_partida),
    .tx_dados   (tx_dados),
    .tx_pronto  (tx_pronto),
    .ocupado    (ocupado),
    .erro       (erro),
    .db_estado  (db_estado),
    .db_vez     (db_vez)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Transmitter stand-in: start, 7 data LSB first, odd parity, stop; pronto during the stop bit.
  logic       modo_auto, pronto_man;
  logic       ativo_q;
  logic [3:0] pos_q;
  logic [9:0] quadro_q;
  logic       serial;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      ativo_q  <= 1'b0;
      pos_q    <= 4'd0;
      quadro_q <= 10'h3FF;
    end else if (tx_partida) begin
      quadro_q <= {1'b1, ~^tx_dados, tx_dados, 1'b0};
      pos_q    <= 4'd0;
      ativo_q  <= 1'b1;
    end else if (ativo_q) begin
      if (pos_q == 4'd9) ativo_q <= 1'b0;
      pos_q <= pos_q + 4'd1;
    end
  end

  assign serial    = ativo_q ? quadro_q[pos_q] : 1'b1;
  assign tx_pronto = (modo_auto && ativo_q && pos_q == 4'd9) || pronto_man;

  task automatic ciclo();
    @(negedge clock);
    ncic++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic espera_partida(input string tag);
    int n = 0;
    while (!tx_partida && n < 60) begin ciclo(); n++; end
    chk(tag, tx_partida, 1);
  endtask

  task automatic espera_ocioso(input string tag);
    int n = 0;
    while (ocupado && n < 60) begin ciclo(); n++; end
    chk(tag, db_estado, 0);
  endtask

  logic [9:0] linha;
  logic       viu_fim;
  int         t0, anterior, n;
  logic [6:0] esperado_dados [4];

  initial begin
    reset = 1'b0; pedido_a = 1'b0; pedido_b = 1'b0;
    dado_a = '0; dado_b = '0; modo_auto = 1'b1; pronto_man = 1'b0;
    esperado_dados[0] = 7'h55; esperado_dados[1] = 7'h7E;
    esperado_dados[2] = 7'h55; esperado_dados[3] = 7'h7E;
    ciclo(); ciclo();
    chk("rst_estado", db_estado, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_partida", tx_partida, 0);
    chk("rst_vez", db_vez, 0);
    chk("rst_dados", tx_dados, 0);
    chk("rst_pulsos", {aceito_a, aceito_b, fim_a, fim_b, erro}, 0);
    reset = 1'b1;
    ciclo();
    chk("ocioso_sem_pedido", db_estado, 0);

    // single request from A, '5'
    dado_a = 7'h35; pedido_a = 1'b1;
    ciclo();
    chk("t1_partida", tx_partida, 1);
    chk("t1_aceito", {aceito_a, aceito_b}, 2'b10);
    chk("t1_dados", tx_dados, 7'h35);
    chk("t1_estado", db_estado, 1);
    pedido_a = 1'b0;
    ciclo();
    chk("t1_partida_1ciclo", {tx_partida, aceito_a}, 0);
    chk("t1_espera", db_estado, 2);
    for (int i = 0; i < 10; i++) begin
      linha[i] = serial;
      ciclo();
    end
    chk("t1_linha", linha, 10'h36A);
    chk("t1_fim", {fim_a, fim_b, erro}, 3'b100);
    chk("t1_estado_fim", db_estado, 3);
    ciclo();
    chk("t1_fim_1ciclo", fim_a, 0);
    chk("t1_vez", db_vez, 1);
    chk("t1_intervalo", db_estado, 5);
    ciclo(); ciclo();
    chk("t1_volta_ocioso", {ocupado, db_estado}, 0);

    // lone requester A wins even with vez=1
    dado_a = 7'h41; pedido_a = 1'b1;
    ciclo();
    chk("rr_aceito", {aceito_a, aceito_b}, 2'b10);
    chk("rr_dados", tx_dados, 7'h41);
    pedido_a = 1'b0;
    n = 0;
    while (!fim_a && n < 40) begin ciclo(); n++; end
    chk("rr_fim", fim_a, 1);
    ciclo();
    chk("rr_vez", db_vez, 1);
    ciclo(); ciclo();
    chk("rr_ocioso", db_estado, 0);

    // reset while B waits in ESPERA
    dado_b = 7'h42; pedido_b = 1'b1;
    ciclo();
    chk("rst_b_aceito", {aceito_a, aceito_b}, 2'b01);
    pedido_b = 1'b0;
    ciclo(); ciclo();
    chk("rst_b_espera", db_estado, 2);
    reset = 1'b0;
    #1;
    chk("rst_async", db_estado, 0);
    ciclo();
    chk("rst_mid_estado", db_estado, 0);
    chk("rst_mid_saidas", {tx_partida, ocupado, db_vez}, 0);
    chk("rst_mid_dados", tx_dados, 0);
    viu_fim = 1'b0;
    for (int i = 0; i < 15; i++) begin
      viu_fim = viu_fim | fim_a | fim_b;
      ciclo();
    end
    chk("rst_mid_sem_fim", viu_fim, 0);
    reset = 1'b1;
    ciclo();

    // contention: A,B,A,B
    dado_a = 7'h55; dado_b = 7'h7E; pedido_a = 1'b1; pedido_b = 1'b1;
    anterior = 0;
    for (int k = 0; k < 4; k++) begin
      espera_partida("ct_partida");
      chk("ct_aceito", {aceito_a, aceito_b}, (k % 2 == 0) ? 2'b10 : 2'b01);
      chk("ct_dados", tx_dados, esperado_dados[k]);
      if (k > 0) chk("ct_espacamento", (ncic - anterior) >= 14, 1);
      anterior = ncic;
      if (k == 3) begin pedido_a = 1'b0; pedido_b = 1'b0; end
      ciclo();
    end
    espera_ocioso("ct_ocioso");
    chk("ct_vez", db_vez, 0);

    // watchdog: transmitter never answers
    modo_auto = 1'b0;
    dado_a = 7'h30; pedido_a = 1'b1;
    espera_partida("to_partida");
    t0 = ncic;
    pedido_a = 1'b0;
    viu_fim = 1'b0;
    n = 0;
    ciclo();
    while (!erro && n < 40) begin
      viu_fim = viu_fim | fim_a | fim_b;
      ciclo();
      n++;
    end
    chk("to_erro", erro, 1);
    chk("to_latencia", ncic - t0, 17);
    chk("to_sem_fim", viu_fim | fim_a, 0);
    chk("to_estado", db_estado, 4);
    ciclo();
    chk("to_erro_1ciclo", erro, 0);
    chk("to_intervalo", db_estado, 5);
    chk("to_vez", db_vez, 1);
    ciclo(); ciclo();
    chk("to_ocioso", db_estado, 0);

    // pronto during PARTIDA ignored; pronto on the timeout cycle wins
    dado_a = 7'h31; pedido_a = 1'b1;
    espera_partida("bd_partida");
    chk("bd_aceito", aceito_a, 1);
    pronto_man = 1'b1; pedido_a = 1'b0;
    ciclo();
    pronto_man = 1'b0;
    chk("bd_partida_ignora_pronto", {db_estado, fim_a}, {4'd2, 1'b0});
    for (int i = 0; i < 15; i++) ciclo();
    chk("bd_ainda_espera", {db_estado, erro}, {4'd2, 1'b0});
    pronto_man = 1'b1;
    ciclo();
    pronto_man = 1'b0;
    chk("bd_fim", {fim_a, erro}, 2'b10);
    chk("bd_estado", db_estado, 3);
    ciclo();
    chk("bd_sem_erro", {erro, db_estado}, {1'b0, 4'd5});
    espera_ocioso("bd_ocioso");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
